pop_dispatcher: RTL
===================

// Module: pop_dispatcher
// PURPOSE
//  Consumer side of the arbiter pop interface: accepts {pop_id, pop_valid} grants, strobes pop on
//  the selected FIFO, captures the returned word (1-cycle FIFO read latency) and presents it
//  downstream with its source id over a valid/ready handshake. Sits between the round-robin
//  arbiter and the egress port; a 2-entry output buffer absorbs the in-flight word under backpressure.
// PARAMETERS
//  DATA_W   8   width of each FIFO data word
//  NUM_FIFO 4   number of source FIFOs (fixed by package constant; id width = 2)
// PORTS
//  clk        in   1            clock, all logic on posedge
//  reset      in   1            synchronous, active-high
//  pop_id     in   2            FIFO selected by arbiter
//  pop_valid  in   1            grant valid this cycle
//  req_ready  out  1            dispatcher can take a grant this cycle
//  fifo_empty in   4            per-FIFO empty flags
//  fifo_data  in   4*DATA_W     FIFO read data, FIFO i at [i*DATA_W +: DATA_W]
//  pop        out  4            one-hot pop strobes to FIFOs
//  data_out   out  DATA_W       word to egress
//  data_id    out  2            source FIFO of data_out
//  data_valid out  1            data_out/data_id valid
//  out_ready  in   1            egress accepts when data_valid & out_ready
//  drop_cnt   out  8            grants discarded because target FIFO was empty (saturates at 255)
// BEHAVIOUR
//  - Reset values: pop=0, data_valid=0, data_out=0, data_id=0, drop_cnt=0, buffer empty, inflight=0.
//  - Grant accepted when pop_valid & req_ready. req_ready = (occ + inflight - deq) < 2,
//    deq = data_valid & out_ready; comb path out_ready->req_ready is intentional (full throughput).
//  - Accepted grant with fifo_empty[pop_id]=0: pop[pop_id]=1 same cycle (comb from registered-free
//    inputs: pop = onehot(pop_id) & accept & ~empty); inflight<=1, inflight_id<=pop_id.
//  - Accepted grant with fifo_empty[pop_id]=1: no pop, drop_cnt+=1 (saturating), nothing enqueued.
//  - pop_valid with req_ready=0: grant ignored, no pop, not counted (arbiter must re-issue).
//  - Cycle after pop: fifo_data slice of inflight_id written to buffer tail with id; inflight<=0
//    unless a new pop issued. Pop-to-data_valid latency = 2 cycles when buffer empty.
//  - Buffer: 2 entries, FIFO order; data_out/data_id/data_valid reflect head (registered).
//    Simultaneous enqueue and dequeue allowed at any occupancy; occ never exceeds 2 (credit guarantees).
//  - data_out/data_id stable while data_valid & ~out_ready.
//  - Reset mid-operation: in-flight word discarded, buffer flushed, pop deasserted same cycle reset is seen.
// CONFIGURATION
//  POP_DISPATCH_STATS_EN defined: adds output pop_cnt (4*16 bits), per-FIFO count of words
//   delivered downstream (incremented on deq by data_id, wraps at 65535->0, cleared by reset).
//  Not defined: port and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package dispatch_pkg: NUM_FIFO=4, ID_W=2, BUF_DEPTH=2, DROP_W=8, typedef fifo_id_t [ID_W-1:0].
//  Sub-module dispatch_buf: 2-entry {id,data} queue with enq/deq/occ; top holds credit, pop, drop logic.
// TESTING
//  1 reset, then pop_valid=1 pop_id=2 fifo_empty=0, fifo_data[2]=8'hA5, out_ready=1 -> pop=4'b0100
//    at cycle 0, data_valid=1 data_out=A5 data_id=2 at cycle 2.
//  2 back-to-back ids 0,1,2,3 every cycle, out_ready=1 -> req_ready stays 1, four words out in order,
//    one per cycle, ids 0..3.
//  3 out_ready=0, grants every cycle -> exactly 2 pops accepted, req_ready=0 after, data_out holds
//    first word; release out_ready -> both words drain in order, req_ready returns 1.
//  4 pop_id=1 with fifo_empty[1]=1 -> pop=0, drop_cnt 0->1, data_valid stays 0; 300 such -> drop_cnt=255.
//  5 reset asserted cycle after a pop -> data_valid=0 next cycle, captured word never appears, drop_cnt=0.
//  6 (POP_DISPATCH_STATS_EN) deliver 3 words from FIFO 3, 1 from FIFO 0 -> pop_cnt[3]=3, pop_cnt[0]=1.

Source files
------------

// File: rtl/pop_dispatcher_pkg.sv
// Shared constants and types for the pop dispatcher slice.
// The optional stats feature is enabled with POP_DISPATCH_STATS_EN.
package dispatch_pkg;
  localparam int NUM_FIFO  = 4;
  localparam int ID_W      = 2;
  localparam int BUF_DEPTH = 2;
  localparam int DROP_W    = 8;
  localparam int CNT_W     = 16;

  typedef logic [ID_W-1:0] fifo_id_t;
  typedef logic [$clog2(BUF_DEPTH+1)-1:0] occ_t;

  function automatic logic [NUM_FIFO-1:0] onehot(input fifo_id_t id);
    logic [NUM_FIFO-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/pop_dispatcher_if.sv
// Grant, FIFO-read and egress signals between the arbiter/FIFOs/egress (master)
// and the pop dispatcher (slave).
interface pop_dispatcher_if #(parameter int DATA_W = 8);
  import dispatch_pkg::*;

  // Handshakes: a grant transfers when pop_valid & req_ready in the same cycle;
  // an egress word transfers when data_valid & out_ready, and data_out/data_id
  // hold steady while data_valid & ~out_ready.
  fifo_id_t                    pop_id;
  logic                        pop_valid;
  logic                        req_ready;
  logic [NUM_FIFO-1:0]         fifo_empty;
  logic [NUM_FIFO*DATA_W-1:0]  fifo_data;
  logic [NUM_FIFO-1:0]         pop;
  logic [DATA_W-1:0]           data_out;
  fifo_id_t                    data_id;
  logic                        data_valid;
  logic                        out_ready;
  logic [DROP_W-1:0]           drop_cnt;

  modport master (
    output pop_id, pop_valid, fifo_empty, fifo_data, out_ready,
    input  req_ready, pop, data_out, data_id, data_valid, drop_cnt
  );

  modport slave (
    input  pop_id, pop_valid, fifo_empty, fifo_data, out_ready,
    output req_ready, pop, data_out, data_id, data_valid, drop_cnt
  );
endinterface

// File: rtl/pop_dispatcher_buf.sv
// Two-entry {id,data} FIFO-ordered output buffer; entry 0 is always the head
// so the head outputs come straight from flops.
module dispatch_buf
  import dispatch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq,
  input  fifo_id_t          enq_id,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output occ_t              occ,
  output fifo_id_t          head_id,
  output logic [DATA_W-1:0] head_data
);
  fifo_id_t          e1_id;
  logic [DATA_W-1:0] e1_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ       <= '0;
      head_id   <= '0;
      head_data <= '0;
      e1_id     <= '0;
      e1_data   <= '0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (occ == occ_t'(0)) begin
            head_id   <= enq_id;
            head_data <= enq_data;
          end else begin
            e1_id   <= enq_id;
            e1_data <= enq_data;
          end
          occ <= occ + occ_t'(1);
        end
        2'b01: begin
          head_id   <= e1_id;
          head_data <= e1_data;
          occ       <= occ - occ_t'(1);
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (occ == occ_t'(1)) begin
            head_id   <= enq_id;
            head_data <= enq_data;
          end else begin
            head_id   <= e1_id;
            head_data <= e1_data;
            e1_id     <= enq_id;
            e1_data   <= enq_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/pop_dispatcher.sv
// Pop dispatcher top: grant credit check, pop strobes, drop counting and read capture.
// Define POP_DISPATCH_STATS_EN to add per-FIFO delivered-word counters on pop_cnt.
module pop_dispatcher
  import dispatch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  pop_dispatcher_if.slave           bus
`ifdef POP_DISPATCH_STATS_EN
  ,
  output logic [NUM_FIFO*CNT_W-1:0] pop_cnt
`endif
);
  occ_t              occ;
  logic              inflight;
  fifo_id_t          inflight_id;
  logic              deq;
  logic              ready_w;
  logic              accept;
  logic              do_pop;
  logic              do_drop;
  logic [2:0]        used;
  fifo_id_t          head_id;
  logic [DATA_W-1:0] head_data;

  // A word in flight already owns a buffer slot, so it counts against credit.
  always_comb begin
    deq            = (occ != occ_t'(0)) & bus.out_ready;
    used           = {1'b0, occ} + {2'b00, inflight};
    ready_w        = used < (3'd2 + {2'b00, deq});
    accept         = bus.pop_valid & ready_w & ~reset;
    do_pop         = accept & ~bus.fifo_empty[bus.pop_id];
    do_drop        = accept & bus.fifo_empty[bus.pop_id];
    bus.req_ready  = ready_w;
    bus.pop        = do_pop ? onehot(bus.pop_id) : '0;
    bus.data_valid = occ != occ_t'(0);
    bus.data_out   = head_data;
    bus.data_id    = head_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight     <= 1'b0;
      inflight_id  <= '0;
      bus.drop_cnt <= '0;
    end else begin
      inflight <= do_pop;
      if (do_pop) inflight_id <= bus.pop_id;
      if (do_drop && bus.drop_cnt != '1) bus.drop_cnt <= bus.drop_cnt + DROP_W'(1);
    end
  end

  dispatch_buf #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .enq       (inflight),
    .enq_id    (inflight_id),
    .enq_data  (bus.fifo_data[inflight_id*DATA_W +: DATA_W]),
    .deq       (deq),
    .occ       (occ),
    .head_id   (head_id),
    .head_data (head_data)
  );

`ifdef POP_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_cnt <= '0;
    end else if (deq) begin
      pop_cnt[head_id*CNT_W +: CNT_W] <= pop_cnt[head_id*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end
`endif
endmodule
